// File: rtl/frame_serializer_pkg.sv
// Shared constants and types for the frame serializer.
package frame_serializer_pkg;

  // Default frame geometry: alien slots, bits per alien record, laser metadata bits.
  localparam int unsigned ObjLimit = 16;
  localparam int unsigned AlienW   = 35;
  localparam int unsigned LaserW   = 14;

  // Start-of-frame marker, first byte of every packet.
  localparam logic [7:0] Sof = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSeq,
    StLen,
    StPayload,
    StCsum
  } state_e;

  // Number of bytes needed to carry a given number of bits.
  function automatic int unsigned bytes_for(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// Captures a parallel game frame and streams it as a byte packet:
// SOF, sequence number, length, payload (LSB first), XOR checksum.
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int unsigned OBJ_LIMIT = ObjLimit,
  parameter int unsigned ALIEN_W   = AlienW,
  parameter int unsigned LASER_W   = LaserW,
  localparam int unsigned FRAME_W  = OBJ_LIMIT * ALIEN_W + LASER_W,
  localparam int unsigned NBYTES   = bytes_for(FRAME_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               frame_load,
  input  logic [FRAME_W-1:0] frame_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               overrun,
  output logic [7:0]         seq_num
);

  localparam int unsigned PadW = NBYTES * 8;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e            r_state;
  state_e            w_state_next;
  logic [PadW-1:0]   r_frame;
  logic [IdxW-1:0]   r_idx;
  logic [7:0]        r_csum;
  logic [7:0]        r_seq;
  logic              r_overrun;

  logic              w_xfer;
  logic              w_capture;
  logic              w_drop;
  logic              w_last;
  logic [PadW-1:0]   w_shift;
  logic [7:0]        w_byte;

  assign w_xfer    = tx_valid & tx_ready;
  assign w_capture = frame_load & en & (r_state == StIdle);
  // CSUM counts as busy, so a load in its transfer cycle lands here too.
  assign w_drop    = frame_load & en & (r_state != StIdle);
  assign w_last    = (r_idx == IdxW'(NBYTES - 1));

  // Current payload byte: shift the captured (zero-padded) frame by the byte index.
  assign w_shift   = r_frame >> {r_idx, 3'b000};
  assign w_byte    = w_shift[7:0];

  assign overrun   = r_overrun;
  assign seq_num   = r_seq;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: every non-idle state advances only on a transfer.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_capture) w_state_next = StHdr;
      StHdr:     if (w_xfer) w_state_next = StSeq;
      StSeq:     if (w_xfer) w_state_next = StLen;
      StLen:     if (w_xfer) w_state_next = StPayload;
      StPayload: if (w_xfer && w_last) w_state_next = StCsum;
      StCsum:    if (w_xfer) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    tx_data  = 8'h00;
    tx_valid = (r_state != StIdle);
    busy     = (r_state != StIdle);
    unique case (r_state)
      StIdle:    tx_data = 8'h00;
      StHdr:     tx_data = Sof;
      StSeq:     tx_data = r_seq;
      StLen:     tx_data = 8'(NBYTES);
      StPayload: tx_data = w_byte;
      StCsum:    tx_data = r_csum;
      default:   tx_data = 8'h00;
    endcase
  end

  // Datapath: frame capture, sequence count, payload index, checksum, sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame   <= '0;
      r_idx     <= '0;
      r_csum    <= 8'h00;
      r_seq     <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      if (w_capture) begin
        r_frame <= PadW'(frame_data);
        r_seq   <= r_seq + 8'd1;
        r_csum  <= 8'h00;
        r_idx   <= '0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_xfer && (r_state == StPayload)) begin
        r_csum <= r_csum ^ w_byte;
        r_idx  <= w_last ? '0 : r_idx + IdxW'(1);
      end
    end
  end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 The module SHALL have parameter OBJ_LIMIT, default 16, meaning the number of alien slots per frame.
REQ-002 The module SHALL have parameter ALIEN_W, default 35, meaning the bits per alien record.
REQ-003 The module SHALL have parameter LASER_W, default 14, meaning the bits of laser metadata.
REQ-004 The module SHALL have localparam FRAME_W = OBJ_LIMIT*ALIEN_W + LASER_W and localparam NBYTES = ceil(FRAME_W/8), default 72.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on the rising clk edge).
REQ-007 The module SHALL have port en, input, 1 bit: load enable. When low, new frames are not captured and an in-flight frame still completes.
REQ-008 The module SHALL have port frame_load, input, 1 bit: one-cycle request to capture frame_data.
REQ-009 The module SHALL have port frame_data, input, FRAME_W bits: the parallel frame with laser metadata in bits [13:0] and alien records above it.
REQ-010 The module SHALL have port tx_data, output, 8 bits: the byte presented downstream.
REQ-011 The module SHALL have port tx_valid, output, 1 bit: tx_data holds a valid byte.
REQ-012 The module SHALL have port tx_ready, input, 1 bit: downstream accepts the byte in this cycle.
REQ-013 The module SHALL have port busy, output, 1 bit: high while a frame is being sent (state != IDLE).
REQ-014 The module SHALL have port overrun, output, 1 bit: sticky flag set when frame_load is dropped.
REQ-015 The module SHALL have port seq_num, output, 8 bits: the sequence number of the last frame captured.

Function
REQ-016 The block SHALL capture frame_data into an internal FRAME_W-bit register only when frame_load=1, en=1 and state=IDLE.
REQ-017 On capture, the block SHALL increment seq_num (mod 256) and enter HDR. tx_valid SHALL rise in the next cycle with tx_data=8'hA5.
REQ-018 The packet SHALL be emitted in this order: 8'hA5, seq_num, NBYTES, NBYTES payload bytes, then checksum.
REQ-019 Payload bytes SHALL go out least-significant byte first; bits above FRAME_W in the last byte SHALL be zero.
REQ-020 The checksum SHALL be the 8-bit XOR of all payload bytes only, accumulated as each payload byte transfers.
REQ-021 The FSM SHALL have states IDLE, HDR, SEQ, LEN, PAYLOAD and CSUM.
REQ-022 FSM transitions:
- Each state SHALL advance only on a transfer (tx_valid & tx_ready).
- PAYLOAD SHALL exit to CSUM after byte NBYTES-1, using an index counter 0..NBYTES-1.
- CSUM SHALL return to IDLE on transfer.
REQ-023 tx_valid SHALL be high in every state except IDLE.
REQ-024 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable and no internal state SHALL change.
REQ-025 A frame_load arriving while busy=1 SHALL be dropped: it sets overrun, does not increment seq_num, and leaves the packet in flight undisturbed.
REQ-026 The cycle in which CSUM transfers SHALL still count as busy, so a frame_load in that same cycle is dropped.
REQ-027 A frame_load arriving when en=0 SHALL be ignored without setting overrun.
REQ-028 With tx_ready held at 1, a packet SHALL take exactly NBYTES+4 cycles from the first tx_valid to the return to IDLE.
REQ-029 A new capture SHALL be possible in the first cycle back in IDLE.
REQ-030 Captured data SHALL be immune to frame_data changes after the capture cycle.

Reset
REQ-031 On rst=0 at a clock edge, all of the following SHALL take effect at that edge:
- state=IDLE, tx_valid=0, tx_data=0, busy=0, overrun=0, seq_num=0;
- checksum and byte index cleared;
- any in-flight packet aborted, with no further bytes emitted.
REQ-032 overrun SHALL clear only on reset.

Structure
REQ-033 OBJ_LIMIT, the laser/alien field widths, the SOF value 8'hA5 and the FSM state enum SHALL live in the shared constants/typedefs package.
REQ-034 No sub-module SHALL be used. Byte selection SHALL use an index-driven mux or right-shift of the captured register, with the checksum inline.

Verification
REQ-035 Scenario 1: reset, then frame_load with frame_data=all-zero and tx_ready=1. Required: bytes A5,01,48, then 72×00, then 00; busy low after 76 cycles.
REQ-036 Scenario 2: frame_data bits [15:0]=16'h1234, rest zero. Required: payload starts 34,12,00…, and the checksum equals 26.
REQ-037 Scenario 3: tx_ready toggles 1-0-1-0 during PAYLOAD. Required: no byte is duplicated or skipped, and tx_data is stable in every ready=0 cycle.
REQ-038 Scenario 4: a second frame_load mid-packet, and another frame_load in the CSUM-transfer cycle. Required: overrun=1, seq_num stays 01, and the packet is intact.
REQ-039 Scenario 5: rst=0 asserted during PAYLOAD byte 10. Required: tx_valid=0 next cycle and seq_num=0; a following load emits A5,01.
REQ-040 Scenario 6: 256 back-to-back frames. Required: seq_num wraps FF to 00.
